// File: rtl/mult_pkg.sv
// -----------------------------------------------------------------------------
// mult_pkg
// Shared declarations for the sequential unsigned multiplier:
//   - mult_state_t : control FSM states (IDLE, BUSY, DONE)
//   - cnt_width()  : width of the iteration counter for a given operand width
//   - mod3()       : modulo-3 residue of an unsigned value up to 64 bits wide
// The residue helper is only used when MULT_RESIDUE_CHECK_EN is defined.
// -----------------------------------------------------------------------------
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mult_state_t;

    // The counter has to reach WIDTH itself, hence WIDTH+1 distinct values.
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

    // 4 == 1 (mod 3), so the residue is the sum of base-4 digits reduced mod 3.
    // Narrower values are zero-extended by the caller.
    function automatic logic [1:0] mod3(input logic [63:0] val);
        logic [2:0] acc;
        acc = 3'd0;
        for (int i = 0; i < 32; i++) begin
            acc = acc + {1'b0, val[2*i +: 2]};
            if (acc >= 3'd3) begin
                acc = acc - 3'd3;
            end else begin
                acc = acc;
            end
            if (acc >= 3'd3) begin
                acc = acc - 3'd3;
            end else begin
                acc = acc;
            end
        end
        return acc[1:0];
    endfunction

endpackage

// File: rtl/mult_mod3_residue.sv
// -----------------------------------------------------------------------------
// mult_mod3_residue
// Combinational modulo-3 reduction of a W-bit unsigned value (W <= 64).
// Ports:
//   val_i [W-1:0]  value to reduce
//   res_o [1:0]    val_i mod 3
// Only compiled when MULT_RESIDUE_CHECK_EN is defined; the default build has
// no residue logic at all.
// -----------------------------------------------------------------------------
`ifdef MULT_RESIDUE_CHECK_EN
module mult_mod3_residue
    import mult_pkg::*;
#(
    parameter int W = 8
) (
    input  logic [W-1:0] val_i,
    output logic [1:0]   res_o
);

    assign res_o = mod3(64'(val_i));

endmodule
`endif

// File: rtl/mult_unsigned_seq.sv
// -----------------------------------------------------------------------------
// mult_unsigned_seq
// Radix-2 shift-add unsigned multiplier, one partial product per cycle.
// Result appears exactly WIDTH cycles after the operands are accepted and is
// held until the consumer takes it.
//
// Parameters:
//   WIDTH      operand width (2..32); product is 2*WIDTH bits
// Ports:
//   clk        clock, all state on rising edge
//   rst        synchronous active-high reset
//   in_valid   operands presented            in_ready  block can accept
//   a, b       unsigned operands (WIDTH)
//   out_valid  product valid                 out_ready consumer accepts
//   p          a*b (2*WIDTH), zero while not valid
//   res_err    residue mismatch, qualified by out_valid
//              (only with MULT_RESIDUE_CHECK_EN defined)
// Configuration macro: MULT_RESIDUE_CHECK_EN enables the mod-3 residue checker.
// -----------------------------------------------------------------------------
module mult_unsigned_seq
    import mult_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] p
`ifdef MULT_RESIDUE_CHECK_EN
    ,
    output logic               res_err
`endif
);

    localparam int                PW       = 2 * WIDTH;
    localparam int                CNT_W    = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(WIDTH - 1);

    mult_state_t      state_q, state_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [PW-1:0]    acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             accept_s;
    logic             handshake_s;
    logic             last_iter_s;
    logic [PW-1:0]    addend_s;

    assign accept_s    = in_valid && (state_q == IDLE);
    assign handshake_s = out_ready && (state_q == DONE);
    assign last_iter_s = (state_q == BUSY) && (cnt_q == LAST_CNT);
    // Multiplicand aligned to the weight of the current multiplier bit.
    assign addend_s    = PW'(mcand_q) << cnt_q;

    // State register: synchronous reset drops any in-flight operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: no early exit, BUSY always runs WIDTH iterations.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    state_d = BUSY;
                end else begin
                    state_d = IDLE;
                end
            end
            BUSY: begin
                if (cnt_q == LAST_CNT) begin
                    state_d = DONE;
                end else begin
                    state_d = BUSY;
                end
            end
            DONE: begin
                if (handshake_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output decode: in_ready only in IDLE, so DONE never accepts same-cycle.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        p         = {PW{1'b0}};
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
            end
            DONE: begin
                out_valid = 1'b1;
                p         = acc_q;
            end
            default: begin
                in_ready  = 1'b0;
                out_valid = 1'b0;
            end
        endcase
    end

    // Datapath next state: load on accept, one shift-add step per BUSY cycle.
    always_comb begin
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    mcand_d  = a;
                    mplier_d = b;
                    acc_d    = {PW{1'b0}};
                    cnt_d    = {CNT_W{1'b0}};
                end else begin
                    mcand_d  = mcand_q;
                end
            end
            BUSY: begin
                if (mplier_q[0]) begin
                    acc_d = acc_q + addend_s;
                end else begin
                    acc_d = acc_q;
                end
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CNT_W'(1);
            end
            default: begin
                acc_d = acc_q;
            end
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            mcand_q  <= {WIDTH{1'b0}};
            mplier_q <= {WIDTH{1'b0}};
            acc_q    <= {PW{1'b0}};
            cnt_q    <= {CNT_W{1'b0}};
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
        end
    end

`ifdef MULT_RESIDUE_CHECK_EN
    logic [1:0] ra_q, ra_d;
    logic [1:0] rb_q, rb_d;
    logic       res_err_q, res_err_d;
    logic [1:0] ra_s, rb_s, rp_s;
    logic [3:0] rab_s;

    mult_mod3_residue #(.W(WIDTH)) u_res_a (.val_i(a),     .res_o(ra_s));
    mult_mod3_residue #(.W(WIDTH)) u_res_b (.val_i(b),     .res_o(rb_s));
    // Checks the value about to be written into the accumulator on entry to DONE.
    mult_mod3_residue #(.W(PW))    u_res_p (.val_i(acc_d), .res_o(rp_s));

    assign rab_s = {2'b00, ra_q} * {2'b00, rb_q};

    // Residue next state: capture operand residues, compare on entry to DONE.
    always_comb begin
        ra_d      = ra_q;
        rb_d      = rb_q;
        res_err_d = res_err_q;
        if (accept_s) begin
            ra_d      = ra_s;
            rb_d      = rb_s;
            res_err_d = 1'b0;
        end else if (last_iter_s) begin
            res_err_d = (mod3(64'(rab_s)) != rp_s);
        end else if (handshake_s) begin
            res_err_d = 1'b0;
        end else begin
            res_err_d = res_err_q;
        end
    end

    // Residue registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            ra_q      <= 2'd0;
            rb_q      <= 2'd0;
            res_err_q <= 1'b0;
        end else begin
            ra_q      <= ra_d;
            rb_q      <= rb_d;
            res_err_q <= res_err_d;
        end
    end

    assign res_err = res_err_q;
`else
    logic unused_last_iter_s;
    assign unused_last_iter_s = last_iter_s;
`endif

endmodule

// File: tb/tb_mult_unsigned_seq.sv
// -----------------------------------------------------------------------------
// tb_mult_unsigned_seq
// Self-checking bench for mult_unsigned_seq at WIDTH=4 and WIDTH=8.
// Expected products come from a constant table (WIDTH=4) or from a*b computed
// by the bench (WIDTH=8), pushed to a scoreboard queue at accept time and
// popped when the product is handed over.
// -----------------------------------------------------------------------------
module tb_mult_unsigned_seq;

    logic clk;
    logic rst;

    logic       in_valid4, in_ready4, out_valid4, out_ready4;
    logic [3:0] a4, b4;
    logic [7:0] p4;

    logic        in_valid8, in_ready8, out_valid8, out_ready8;
    logic [7:0]  a8, b8;
    logic [15:0] p8;

`ifdef MULT_RESIDUE_CHECK_EN
    logic err4, err8;
`endif

    int n_run;
    int n_fail;

    logic [63:0] sb4[$];
    logic [63:0] sb8[$];

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [7:0] exp_p;
        int         hold;
        bit         poke;
    } vec4_t;

    vec4_t tbl[8];

    mult_unsigned_seq #(.WIDTH(4)) dut4 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid4),
        .in_ready  (in_ready4),
        .a         (a4),
        .b         (b4),
        .out_valid (out_valid4),
        .out_ready (out_ready4),
        .p         (p4)
`ifdef MULT_RESIDUE_CHECK_EN
        ,
        .res_err   (err4)
`endif
    );

    mult_unsigned_seq #(.WIDTH(8)) dut8 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid8),
        .in_ready  (in_ready8),
        .a         (a8),
        .b         (b8),
        .out_valid (out_valid8),
        .out_ready (out_ready8),
        .p         (p8)
`ifdef MULT_RESIDUE_CHECK_EN
        ,
        .res_err   (err8)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one cycle and land 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // One WIDTH=4 transaction with optional backpressure and in_valid pokes in BUSY.
    task automatic op4(input logic [3:0] av, input logic [3:0] bv, input logic [7:0] ev,
                       input int hold, input bit poke);
        int n;
        logic [63:0] expv;
        n = 0;
        while (!in_ready4 && n < 50) begin
            step();
            n++;
        end
        chk("in_ready4_idle", 64'(in_ready4), 64'd1);
        a4 = av;
        b4 = bv;
        in_valid4 = 1'b1;
        sb4.push_back(64'(ev));
        step();
        in_valid4 = 1'b0;
        n = 0;
        while (!out_valid4 && n < 50) begin
            if (poke && n < 2) begin
                in_valid4 = 1'b1;
                a4 = ~av;
                b4 = ~bv;
            end else begin
                in_valid4 = 1'b0;
            end
            step();
            n++;
            if (poke && n < 3) chk("in_ready4_busy", 64'(in_ready4), 64'd0);
        end
        in_valid4 = 1'b0;
        chk("latency4", 64'(n), 64'd4);
        chk("in_ready4_done", 64'(in_ready4), 64'd0);
        for (int h = 0; h < hold; h++) begin
            step();
            chk("out_valid4_hold", 64'(out_valid4), 64'd1);
            chk("p4_hold", 64'(p4), sb4[0]);
        end
`ifdef MULT_RESIDUE_CHECK_EN
        chk("res_err4_clean", 64'(err4), 64'd0);
`endif
        expv = (sb4.size() > 0) ? sb4.pop_front() : 64'hFFFF_FFFF_FFFF_FFFF;
        chk("p4", 64'(p4), expv);
        out_ready4 = 1'b1;
        step();
        out_ready4 = 1'b0;
        chk("out_valid4_after_hs", 64'(out_valid4), 64'd0);
        chk("in_ready4_after_hs", 64'(in_ready4), 64'd1);
    endtask

    // One WIDTH=8 transaction, consumer always ready.
    task automatic op8(input logic [7:0] av, input logic [7:0] bv, input logic [15:0] ev,
                       input bit chk_lat);
        int n;
        logic [63:0] expv;
        n = 0;
        while (!in_ready8 && n < 50) begin
            step();
            n++;
        end
        a8 = av;
        b8 = bv;
        in_valid8 = 1'b1;
        sb8.push_back(64'(ev));
        step();
        in_valid8 = 1'b0;
        n = 0;
        while (!out_valid8 && n < 50) begin
            step();
            n++;
        end
        if (chk_lat) chk("latency8", 64'(n), 64'd8);
        if (n >= 50) chk("timeout8", 64'(n), 64'd8);
        expv = (sb8.size() > 0) ? sb8.pop_front() : 64'hFFFF_FFFF_FFFF_FFFF;
        chk("p8", 64'(p8), expv);
        out_ready8 = 1'b1;
        step();
        out_ready8 = 1'b0;
    endtask

    initial begin
        int seen;
        logic [7:0] ra, rb;

        n_run = 0;
        n_fail = 0;
        rst = 1'b1;
        in_valid4 = 1'b0; out_ready4 = 1'b0; a4 = 4'd0; b4 = 4'd0;
        in_valid8 = 1'b0; out_ready8 = 1'b0; a8 = 8'd0; b8 = 8'd0;

        tbl[0] = '{4'd15, 4'd15, 8'd225, 0,  1'b0};
        tbl[1] = '{4'd0,  4'd9,  8'd0,   0,  1'b1};
        tbl[2] = '{4'd9,  4'd1,  8'd9,   0,  1'b1};
        tbl[3] = '{4'd6,  4'd7,  8'd42,  10, 1'b0};
        tbl[4] = '{4'd0,  4'd0,  8'd0,   0,  1'b0};
        tbl[5] = '{4'd1,  4'd15, 8'd15,  0,  1'b0};
        tbl[6] = '{4'd10, 4'd12, 8'd120, 2,  1'b0};
        tbl[7] = '{4'd15, 4'd1,  8'd15,  0,  1'b0};

        step();
        step();
        chk("rst_in_ready4",  64'(in_ready4),  64'd1);
        chk("rst_out_valid4", 64'(out_valid4), 64'd0);
        chk("rst_p4",         64'(p4),         64'd0);
        chk("rst_in_ready8",  64'(in_ready8),  64'd1);
        chk("rst_out_valid8", 64'(out_valid8), 64'd0);
`ifdef MULT_RESIDUE_CHECK_EN
        chk("rst_res_err4",   64'(err4),       64'd0);
`endif
        rst = 1'b0;
        step();

        for (int i = 0; i < 8; i++) begin
            op4(tbl[i].a, tbl[i].b, tbl[i].exp_p, tbl[i].hold, tbl[i].poke);
        end

        // Reset two cycles into BUSY: the 13*11 result must never appear.
        a4 = 4'd13;
        b4 = 4'd11;
        in_valid4 = 1'b1;
        step();
        in_valid4 = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
        chk("midrst_in_ready4",  64'(in_ready4),  64'd1);
        chk("midrst_out_valid4", 64'(out_valid4), 64'd0);
        chk("midrst_p4",         64'(p4),         64'd0);
        rst = 1'b0;
        out_ready4 = 1'b1;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (out_valid4 || p4 == 8'd143) seen++;
        end
        out_ready4 = 1'b0;
        chk("midrst_no_emit", 64'(seen), 64'd0);
        chk("midrst_idle", 64'(in_ready4), 64'd1);

        op4(4'd3, 4'd5, 8'd15, 0, 1'b0);

`ifdef MULT_RESIDUE_CHECK_EN
        // Corrupt the accumulator during the last BUSY cycle of 5*3.
        begin
            logic [7:0] bad;
            a4 = 4'd5;
            b4 = 4'd3;
            in_valid4 = 1'b1;
            step();
            in_valid4 = 1'b0;
            step();
            step();
            step();
            bad = dut4.acc_q ^ 8'h01;
            force dut4.acc_q = bad;
            step();
            release dut4.acc_q;
            chk("res_err_out_valid", 64'(out_valid4), 64'd1);
            chk("res_err_flag", 64'(err4), 64'd1);
            out_ready4 = 1'b1;
            step();
            out_ready4 = 1'b0;
            chk("res_err_cleared", 64'(err4), 64'd0);
        end
`endif

        op8(8'd255, 8'd255, 16'd65025, 1'b1);
        op8(8'd0,   8'd200, 16'd0,     1'b1);
        op8(8'd128, 8'd2,   16'd256,   1'b1);
        for (int i = 0; i < 1000; i++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            op8(ra, rb, 16'(ra) * 16'(rb), 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation exceeded time limit, %0d tests run", n_run);
        $fatal(1, "watchdog");
    end

endmodule
